// File: rtl/bus_demux_pkg.sv
// Shared Avalon-MM widths, error-responder constants and FSM state encodings
// used by the bus demux and the other crossbar blocks.
package bus_demux_pkg;

  localparam int AV_ADDR_W = 30;
  localparam int AV_DATA_W = 32;
  localparam int AV_BE_W   = 4;
  localparam int ERR_CNT_W = 8;

  localparam logic [AV_DATA_W-1:0] ERR_READ_DATA = 32'h0000_0000;

  // Error responder: IDLE stalls an unmapped access for one cycle, ERR_ACK accepts it.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_ERR_ACK = 1'b1
  } err_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_demux_if.sv
// Avalon-MM bus bundle: one upstream master port and NUM_OUTPUTS downstream
// slave ports, flattened into packed vectors (slave i at [W*i +: W]).
//
// Handshake: a request (Read or Write) is held by the master until a cycle in
// which WaitRequest is 0; that cycle is the acceptance. Read data returns with
// ReadDataValid exactly one cycle after a read acceptance, with no back-pressure.
interface bus_demux_if
  import bus_demux_pkg::*;
#(
  parameter int NUM_OUTPUTS = 2
);
  logic [AV_ADDR_W-1:0]             i_AVIn_Addr;
  logic [AV_BE_W-1:0]               i_AVIn_ByteEn;
  logic                             i_AVIn_Read;
  logic                             i_AVIn_Write;
  logic [AV_DATA_W-1:0]             i_AVIn_WriteData;
  logic [AV_DATA_W-1:0]             o_AVIn_ReadData;
  logic                             o_AVIn_ReadDataValid;
  logic                             o_AVIn_WaitRequest;

  logic [AV_ADDR_W*NUM_OUTPUTS-1:0] o_AVOut_Addr;
  logic [AV_BE_W*NUM_OUTPUTS-1:0]   o_AVOut_ByteEn;
  logic [NUM_OUTPUTS-1:0]           o_AVOut_Read;
  logic [NUM_OUTPUTS-1:0]           o_AVOut_Write;
  logic [AV_DATA_W*NUM_OUTPUTS-1:0] o_AVOut_WriteData;
  logic [AV_DATA_W*NUM_OUTPUTS-1:0] i_AVOut_ReadData;
  logic [NUM_OUTPUTS-1:0]           i_AVOut_WaitRequest;

  // The demux side of the bundle.
  modport slave (
    input  i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write, i_AVIn_WriteData,
    output o_AVIn_ReadData, o_AVIn_ReadDataValid, o_AVIn_WaitRequest,
    output o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData,
    input  i_AVOut_ReadData, i_AVOut_WaitRequest
  );

  // The environment side: upstream master plus the downstream slaves.
  modport master (
    output i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write, i_AVIn_WriteData,
    input  o_AVIn_ReadData, o_AVIn_ReadDataValid, o_AVIn_WaitRequest,
    input  o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData,
    output i_AVOut_ReadData, i_AVOut_WaitRequest
  );
endinterface

// File: rtl/bus_demux_addr_decoder.sv
// Combinational address decoder: per-slave base/mask match, lowest index wins,
// plus a hit flag for "some slave matched".
module bus_demux_addr_decoder
  import bus_demux_pkg::*;
#(
  parameter int                               NUM_OUTPUTS = 2,
  parameter int                               SEL_W       = 1,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] BASE_ADDRS  = '0,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] ADDR_MASKS  = '0
) (
  input  logic [AV_ADDR_W-1:0] addr,
  output logic                 hit,
  output logic [SEL_W-1:0]     sel
);

  logic [NUM_OUTPUTS-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_match
      assign match[gi] = ((addr & ADDR_MASKS[AV_ADDR_W*gi +: AV_ADDR_W])
                          == BASE_ADDRS[AV_ADDR_W*gi +: AV_ADDR_W]);
    end
  endgenerate

  // Priority encode: scan downwards so the lowest matching index is left in sel.
  always_comb begin
    hit = |match;
    sel = '0;
    for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
      if (match[i]) sel = SEL_W'(i);
    end
  end

endmodule

// File: rtl/bus_demux.sv
// One Avalon-MM master fanned out to NUM_OUTPUTS slaves by address decode,
// with one-cycle read-return routing and a decode-error responder that
// stalls, then acks, unmapped accesses and records them in sticky registers.
module bus_demux
  import bus_demux_pkg::*;
#(
  parameter int                               NUM_OUTPUTS = 2,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] BASE_ADDRS  = '0,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] ADDR_MASKS  = '0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  bus_demux_if.slave           bus,
  input  logic                 i_ErrClr,
  output logic                 o_ErrFlag,
  output logic [AV_ADDR_W-1:0] o_ErrAddr,
  output logic [ERR_CNT_W-1:0] o_ErrCount,
  output err_state_e           o_dbg_state
);

  localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  logic                 dec_hit;
  logic [SEL_W-1:0]     dec_sel;

  err_state_e           state_q, state_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_err_q, rd_err_d;
  logic [SEL_W-1:0]     rd_sel_q, rd_sel_d;
  logic                 err_flag_q, err_flag_d;
  logic [AV_ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic req, rd_only, map_hit, wait_w, rd_accept, err_capture;

  bus_demux_addr_decoder #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .SEL_W       (SEL_W),
    .BASE_ADDRS  (BASE_ADDRS),
    .ADDR_MASKS  (ADDR_MASKS)
  ) u_dec (
    .addr (bus.i_AVIn_Addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // Request classification; during ERR_ACK the decode is forced to the error path
  // so the ack completes even if the master moved its address.
  always_comb begin
    req         = bus.i_AVIn_Read | bus.i_AVIn_Write;
    rd_only     = bus.i_AVIn_Read & ~bus.i_AVIn_Write;
    map_hit     = dec_hit & (state_q == ST_IDLE);
    wait_w      = map_hit ? bus.i_AVOut_WaitRequest[dec_sel] : (req & (state_q == ST_IDLE));
    rd_accept   = rd_only & ~wait_w;
    err_capture = req & ~dec_hit & (state_q == ST_IDLE);
  end

  // Broadcast address/data, gate strobes to the selected slave, route read return.
  always_comb begin
    bus.o_AVOut_Addr      = {NUM_OUTPUTS{bus.i_AVIn_Addr}};
    bus.o_AVOut_ByteEn    = {NUM_OUTPUTS{bus.i_AVIn_ByteEn}};
    bus.o_AVOut_WriteData = {NUM_OUTPUTS{bus.i_AVIn_WriteData}};
    bus.o_AVOut_Read      = '0;
    bus.o_AVOut_Write     = '0;
    if (map_hit) begin
      bus.o_AVOut_Read[dec_sel]  = rd_only;
      bus.o_AVOut_Write[dec_sel] = bus.i_AVIn_Write;
    end
    bus.o_AVIn_WaitRequest   = wait_w;
    bus.o_AVIn_ReadDataValid = rd_pend_q;
    bus.o_AVIn_ReadData      = '0;
    if (rd_pend_q) begin
      bus.o_AVIn_ReadData = rd_err_q ? ERR_READ_DATA
                                     : bus.i_AVOut_ReadData[AV_DATA_W*rd_sel_q +: AV_DATA_W];
    end
  end

  // Next state: error FSM, read-return tracking and sticky error capture
  // (a new capture beats a simultaneous clear).
  always_comb begin
    state_d    = err_capture ? ST_ERR_ACK : ST_IDLE;
    rd_pend_d  = rd_accept;
    rd_sel_d   = rd_sel_q;
    rd_err_d   = rd_err_q;
    if (rd_accept) begin
      rd_sel_d = map_hit ? dec_sel : '0;
      rd_err_d = ~map_hit;
    end
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (err_capture) begin
      err_flag_d = 1'b1;
      err_addr_d = bus.i_AVIn_Addr;
      err_cnt_d  = i_ErrClr ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
    end else if (i_ErrClr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end
  end

  // All state registers; reset drops any pending read return.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_sel_q   <= '0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_err_q   <= rd_err_d;
      rd_sel_q   <= rd_sel_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_ErrFlag   = err_flag_q;
  assign o_ErrAddr   = err_addr_q;
  assign o_ErrCount  = err_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bus_demux.sv
// Bench for bus_demux with two slaves at 0x000 and 0x100 (256-word windows):
// directed corner sequences, a decode vector table, then random traffic
// checked against a transaction-level reference model.
module tb_bus_demux;
  import bus_demux_pkg::*;

  localparam int N = 2;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_flag;
  logic [29:0] err_addr;
  logic [7:0]  err_cnt;
  err_state_e  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [29:0] base_a [N];
  logic [29:0] mask_a [N];
  logic [31:0] srd    [N];

  bus_demux_if #(.NUM_OUTPUTS(N)) bus ();

  bus_demux #(
    .NUM_OUTPUTS (N),
    .BASE_ADDRS  ({30'h100, 30'h000}),
    .ADDR_MASKS  ({30'h3FFFFF00, 30'h3FFFFF00})
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .bus         (bus),
    .i_ErrClr    (err_clr),
    .o_ErrFlag   (err_flag),
    .o_ErrAddr   (err_addr),
    .o_ErrCount  (err_cnt),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.i_AVIn_Addr         = '0;
    bus.i_AVIn_ByteEn       = 4'hF;
    bus.i_AVIn_Read         = 1'b0;
    bus.i_AVIn_Write        = 1'b0;
    bus.i_AVIn_WriteData    = '0;
    bus.i_AVOut_WaitRequest = '0;
    err_clr                 = 1'b0;
  endtask

  task automatic drive_req(input logic [29:0] a, input logic rd, input logic wr, input logic [1:0] wt);
    bus.i_AVIn_Addr         = a;
    bus.i_AVIn_Read         = rd;
    bus.i_AVIn_Write        = wr;
    bus.i_AVOut_WaitRequest = wt;
  endtask

  task automatic set_srd(input logic [31:0] d0, input logic [31:0] d1);
    srd[0] = d0;
    srd[1] = d1;
    bus.i_AVOut_ReadData = {srd[1], srd[0]};
  endtask

  // Reference decode: first slave whose masked address equals its base, else -1.
  function automatic int ref_decode(input logic [29:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & mask_a[i]) == base_a[i]) return i;
    end
    return -1;
  endfunction

  typedef struct {
    logic [29:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  wt;
    logic [1:0]  e_rd;
    logic [1:0]  e_wr;
    logic        e_wait;
  } vec_t;

  vec_t tbl [7];

  // Scoreboard for the random phase: source of each expected read return (-1 = error responder).
  int          exp_q [$];
  logic [31:0] exp_data;
  logic        m_ack;
  logic        m_flag;
  logic [29:0] m_eaddr;
  int          m_cnt;

  initial begin
    base_a[0] = 30'h000; base_a[1] = 30'h100;
    mask_a[0] = 30'h3FFFFF00; mask_a[1] = 30'h3FFFFF00;
    tbl[0] = '{30'h000, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
    tbl[1] = '{30'h0FF, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1};
    tbl[2] = '{30'h1FF, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1};
    tbl[3] = '{30'h100, 1'b0, 1'b1, 2'b01, 2'b00, 2'b10, 1'b0};
    tbl[4] = '{30'h150, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0};
    tbl[5] = '{30'h080, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    tbl[6] = '{30'h0AB, 1'b1, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0};

    drive_idle();
    set_srd(32'h0, 32'h0);

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", bus.o_AVIn_ReadDataValid, 1'b0);
    chk("rst_rdata", bus.o_AVIn_ReadData, 32'h0);
    chk("rst_flag", err_flag, 1'b0);
    chk("rst_eaddr", err_addr, 30'h0);
    chk("rst_ecnt", err_cnt, 8'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Write to slave 1 held off by its wait, then accepted.
    drive_req(30'h105, 1'b0, 1'b1, 2'b10);
    bus.i_AVIn_WriteData = 32'hA5A5A5A5;
    bus.i_AVIn_ByteEn    = 4'hC;
    @(negedge clk);
    chk("wr1_write", bus.o_AVOut_Write, 2'b10);
    chk("wr1_read", bus.o_AVOut_Read, 2'b00);
    chk("wr1_wait_hi", bus.o_AVIn_WaitRequest, 1'b1);
    chk("wr1_wdata", bus.o_AVOut_WriteData, {32'hA5A5A5A5, 32'hA5A5A5A5});
    chk("wr1_be", bus.o_AVOut_ByteEn, 8'hCC);
    chk("wr1_addr", bus.o_AVOut_Addr, {30'h105, 30'h105});
    cyc();
    bus.i_AVOut_WaitRequest = 2'b00;
    @(negedge clk);
    chk("wr1_wait_lo", bus.o_AVIn_WaitRequest, 1'b0);
    chk("wr1_write2", bus.o_AVOut_Write, 2'b10);
    cyc();
    drive_idle();

    // Single read from slave 0.
    drive_req(30'h010, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    chk("rd0_read", bus.o_AVOut_Read, 2'b01);
    chk("rd0_wait", bus.o_AVIn_WaitRequest, 1'b0);
    cyc();
    drive_idle();
    set_srd(32'h12345678, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd0_valid", bus.o_AVIn_ReadDataValid, 1'b1);
    chk("rd0_data", bus.o_AVIn_ReadData, 32'h12345678);
    chk("rd0_read_off", bus.o_AVOut_Read, 2'b00);
    cyc();
    @(negedge clk);
    chk("rd0_valid_off", bus.o_AVIn_ReadDataValid, 1'b0);
    chk("rd0_data_off", bus.o_AVIn_ReadData, 32'h0);
    cyc();

    // Back-to-back reads: slave 0 then slave 1.
    drive_req(30'h020, 1'b1, 1'b0, 2'b00);
    cyc();
    drive_req(30'h120, 1'b1, 1'b0, 2'b00);
    set_srd(32'h11110000, 32'h99999999);
    @(negedge clk);
    chk("b2b_read1", bus.o_AVOut_Read, 2'b10);
    chk("b2b_valid0", bus.o_AVIn_ReadDataValid, 1'b1);
    chk("b2b_data0", bus.o_AVIn_ReadData, 32'h11110000);
    cyc();
    drive_idle();
    set_srd(32'h77777777, 32'h22220000);
    @(negedge clk);
    chk("b2b_valid1", bus.o_AVIn_ReadDataValid, 1'b1);
    chk("b2b_data1", bus.o_AVIn_ReadData, 32'h22220000);
    cyc();

    // Unmapped read: stall, ack, zero data, error capture.
    drive_req(30'h3000, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    chk("err_wait_hi", bus.o_AVIn_WaitRequest, 1'b1);
    chk("err_no_fwd", bus.o_AVOut_Read, 2'b00);
    cyc();
    @(negedge clk);
    chk("err_wait_lo", bus.o_AVIn_WaitRequest, 1'b0);
    chk("err_state", dbg_state, ST_ERR_ACK);
    chk("err_flag", err_flag, 1'b1);
    chk("err_addr", err_addr, 30'h3000);
    chk("err_cnt", err_cnt, 8'd1);
    cyc();
    drive_idle();
    set_srd(32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    chk("err_valid", bus.o_AVIn_ReadDataValid, 1'b1);
    chk("err_rdata", bus.o_AVIn_ReadData, 32'h0);
    chk("err_idle", dbg_state, ST_IDLE);
    cyc();

    // Clear, 256 unmapped writes to saturation, then clear together with a new error.
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_flag", err_flag, 1'b0);
    chk("clr_cnt", err_cnt, 8'd0);
    drive_req(30'h2000, 1'b0, 1'b1, 2'b00);
    for (int k = 0; k < 512; k++) begin
      cyc();
      if (k == 507) chk("sat_cnt254", err_cnt, 8'd254);
    end
    @(negedge clk);
    chk("sat_cnt255", err_cnt, 8'd255);
    chk("sat_flag", err_flag, 1'b1);
    chk("sat_wait", bus.o_AVIn_WaitRequest, 1'b1);
    bus.i_AVIn_Addr = 30'h2F00;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clrwin_flag", err_flag, 1'b1);
    chk("clrwin_cnt", err_cnt, 8'd1);
    chk("clrwin_addr", err_addr, 30'h2F00);
    cyc();
    drive_idle();
    cyc();

    // Reset in the cycle after a read acceptance drops the return.
    drive_req(30'h010, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    chk("rstrd_read", bus.o_AVOut_Read, 2'b01);
    cyc();
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rstrd_valid", bus.o_AVIn_ReadDataValid, 1'b0);
    chk("rstrd_rdata", bus.o_AVIn_ReadData, 32'h0);
    chk("rstrd_flag", err_flag, 1'b0);
    chk("rstrd_cnt", err_cnt, 8'd0);
    chk("rstrd_eaddr", err_addr, 30'h0);
    @(negedge clk);
    chk("rstrd_valid2", bus.o_AVIn_ReadDataValid, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Decode vector table (mapped addresses only).
    for (int t = 0; t < 7; t++) begin
      drive_req(tbl[t].addr, tbl[t].rd, tbl[t].wr, tbl[t].wt);
      @(negedge clk);
      chk($sformatf("tbl%0d_read", t), bus.o_AVOut_Read, tbl[t].e_rd);
      chk($sformatf("tbl%0d_write", t), bus.o_AVOut_Write, tbl[t].e_wr);
      chk($sformatf("tbl%0d_wait", t), bus.o_AVIn_WaitRequest, tbl[t].e_wait);
      cyc();
    end
    drive_idle();

    // Random traffic against the reference model, starting from a fresh reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    m_ack   = 1'b0;
    m_flag  = 1'b0;
    m_eaddr = '0;
    m_cnt   = 0;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic [29:0] a;
      logic        rd, wr, req, is_rd, e_wait, cap;
      logic [1:0]  wt, e_rd, e_wr;
      int          tgt, src;
      case ($urandom_range(0, 3))
        0: a = 30'($urandom_range(0, 'hFF));
        1: a = 30'('h100 + $urandom_range(0, 'hFF));
        2: a = 30'($urandom);
        default: a = 30'('h200 + $urandom_range(0, 'h3F));
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wt = 2'($urandom_range(0, 3));
      drive_req(a, rd, wr, wt);
      bus.i_AVIn_WriteData = $urandom;
      err_clr = ($urandom_range(0, 9) == 0);
      set_srd($urandom, $urandom);
      @(negedge clk);

      req   = rd | wr;
      is_rd = rd & ~wr;
      tgt   = m_ack ? -1 : ref_decode(a);
      e_wait = (tgt >= 0) ? wt[tgt] : (req & ~m_ack);
      e_rd  = '0;
      e_wr  = '0;
      if (tgt >= 0) begin
        e_rd[tgt] = is_rd;
        e_wr[tgt] = wr;
      end
      if (exp_q.size() > 0) begin
        src = exp_q.pop_front();
        exp_data = (src < 0) ? 32'h0 : srd[src];
        chk("rnd_valid", bus.o_AVIn_ReadDataValid, 1'b1);
      end else begin
        exp_data = 32'h0;
        chk("rnd_valid", bus.o_AVIn_ReadDataValid, 1'b0);
      end
      chk("rnd_rdata", bus.o_AVIn_ReadData, exp_data);
      chk("rnd_read", bus.o_AVOut_Read, e_rd);
      chk("rnd_write", bus.o_AVOut_Write, e_wr);
      chk("rnd_wait", bus.o_AVIn_WaitRequest, e_wait);
      chk("rnd_flag", err_flag, m_flag);
      chk("rnd_eaddr", err_addr, m_eaddr);
      chk("rnd_ecnt", err_cnt, 8'(m_cnt));
      chk("rnd_state", dbg_state, m_ack ? ST_ERR_ACK : ST_IDLE);

      if (is_rd && !e_wait) exp_q.push_back(tgt);
      cap = req & ~m_ack & (tgt < 0);
      if (cap) begin
        m_flag  = 1'b1;
        m_eaddr = a;
        m_cnt   = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (err_clr) begin
        m_flag = 1'b0;
        m_cnt  = 0;
      end
      m_ack = cap;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
